prog_loader: RTL and testbench

Program loader that writes packed instructions into the instruction memory read by `mem_controller`, then starts that controller and waits for its done flag. It accepts decoded instruction fields (opcode, dest, src1, src2) over a valid/ready stream and packs each into one 16-bit word. It writes the words to consecutive addresses from 0, then holds `S` high until `d` returns. It sits between the test/host side and the memory/controller pair, on the write end of the memory that `mem_controller` fetches from.

---
 rtl/prog_loader_pkg.sv | 34 +++
 rtl/prog_loader_if.sv | 38 +++
 rtl/prog_loader.sv | 136 +++++++++++++
 tb/tb_prog_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the program loader and the
// mem_controller decode side: state encoding, field/word widths and the
// instruction packing helper.
package prog_loader_pkg;

   // Instruction field and packed word widths
   localparam int FIELD_W = 4;
   localparam int WORD_W  = 16;

   // Loader state encoding (visible on the curr output)
   localparam logic [1:0] ENC_IDLE  = 2'd0;
   localparam logic [1:0] ENC_LOAD  = 2'd1;
   localparam logic [1:0] ENC_FLUSH = 2'd2;
   localparam logic [1:0] ENC_RUN   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = ENC_IDLE,
      ST_LOAD  = ENC_LOAD,
      ST_FLUSH = ENC_FLUSH,
      ST_RUN   = ENC_RUN
   } state_t;

   // Packs decoded fields into one memory word: {opcode, dest, src1, src2}.
   // Pure concatenation, the fields are never combined arithmetically.
   function automatic logic [WORD_W-1:0] pack_instr(
      input logic [FIELD_W-1:0] opcode,
      input logic [FIELD_W-1:0] dest,
      input logic [FIELD_W-1:0] src1,
      input logic [FIELD_W-1:0] src2
   );
      return {opcode, dest, src1, src2};
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: instruction stream, memory write port and start/done pair
// of the program loader.
//
// Stream handshake: the sender drives in_valid with stable fields and
// in_last; the loader drives in_ready. A word moves on a rising clk edge
// where in_valid and in_ready are both 1. in_ready never depends on
// in_valid, so the sender may hold in_valid high indefinitely.
interface prog_loader_if #(
   parameter int ADDR_W = 4
);
   import prog_loader_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [FIELD_W-1:0] in_opcode;
   logic [FIELD_W-1:0] in_dest;
   logic [FIELD_W-1:0] in_src1;
   logic [FIELD_W-1:0] in_src2;
   logic               in_last;
   logic               mem_we;
   logic [ADDR_W-1:0]  mem_addr;
   logic [WORD_W-1:0]  mem_wdata;
   logic               S;
   logic               d;

   // Host/memory/controller side
   modport master (
      output in_valid, in_opcode, in_dest, in_src1, in_src2, in_last, d,
      input  in_ready, mem_we, mem_addr, mem_wdata, S
   );

   // Loader side
   modport slave (
      input  in_valid, in_opcode, in_dest, in_src1, in_src2, in_last, d,
      output in_ready, mem_we, mem_addr, mem_wdata, S
   );

endinterface

// File: rtl/prog_loader.sv
// prog_loader: packs incoming instruction fields into 16-bit words, writes
// them to consecutive memory addresses from 0, then holds S high until the
// controller returns d. Words arriving once the memory is full are dropped
// and flagged on the sticky overflow output.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a running XOR of all
// written words on the checksum output.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   prog_loader_if.slave      bus,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
`ifdef PROG_LOADER_CHECKSUM_EN
   output logic [WORD_W-1:0] checksum,
`endif
   output logic [1:0]        curr
);

   // count value at which the memory holds all 2**ADDR_W words
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(1) << ADDR_W;

   state_t              r_state;
   state_t              w_next;
   logic                w_ready;
   logic                w_start;
   logic                w_xfer;
   logic                w_first;
   logic                w_full;
   logic                w_write;
   logic [ADDR_W-1:0]   w_addr;
   logic [WORD_W-1:0]   w_word;

   logic [ADDR_W:0]     r_count;
   logic                r_overflow;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [WORD_W-1:0]   r_mem_wdata;

   assign w_xfer  = bus.in_valid & w_ready;
   // The first word of a program restarts addressing, so it is never "full"
   // even though count may still show the previous program's 2**ADDR_W.
   assign w_first = w_xfer & (r_state == ST_IDLE);
   assign w_full  = (r_count == FULL_CNT);
   assign w_write = w_xfer & (w_first | ~w_full);
   // count doubles as the next free address while loading
   assign w_addr  = w_first ? '0 : r_count[ADDR_W-1:0];
   assign w_word  = pack_instr(bus.in_opcode, bus.in_dest, bus.in_src1, bus.in_src2);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic; d only matters in RUN
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_xfer) w_next = bus.in_last ? ST_FLUSH : ST_LOAD;
         ST_LOAD:  if (w_xfer && bus.in_last) w_next = ST_FLUSH;
         ST_FLUSH: w_next = ST_RUN;
         ST_RUN:   if (bus.d) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // State-decoded outputs: accept in IDLE/LOAD, start level in RUN
   always_comb begin
      w_ready = 1'b0;
      w_start = 1'b0;
      unique case (r_state)
         ST_IDLE:  w_ready = 1'b1;
         ST_LOAD:  w_ready = 1'b1;
         ST_FLUSH: w_ready = 1'b0;
         ST_RUN:   w_start = 1'b1;
         default:  w_ready = 1'b0;
      endcase
   end

   // Word count and sticky overflow, both restarted by a program's first word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (w_first) begin
         r_count    <= (ADDR_W+1)'(1);
         r_overflow <= 1'b0;
      end else if (w_write) begin
         r_count    <= r_count + (ADDR_W+1)'(1);
      end else if (w_xfer && w_full) begin
         r_overflow <= 1'b1;
      end
   end

   // Registered memory write port: one strobe per accepted, non-dropped word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_we <= w_write;
         if (w_write) begin
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_word;
         end
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] r_checksum;

   // Running XOR of written words, updated together with mem_we
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        r_checksum <= '0;
      else if (w_first) r_checksum <= w_word;
      else if (w_write) r_checksum <= r_checksum ^ w_word;
   end

   assign checksum = r_checksum;
`endif

   assign bus.in_ready  = w_ready;
   assign bus.S         = w_start;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign count         = r_count;
   assign overflow      = r_overflow;
   assign curr          = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader. Expected memory writes go
// into a queue when a word is sent and are matched by a write monitor.
module tb_prog_loader;

   localparam int ADDR_W = 4;

   logic              clk;
   logic              reset;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic [1:0]        curr;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [15:0]       checksum;
`endif

   int checks = 0;
   int errors = 0;
   logic [ADDR_W+15:0] exp_q[$];

   prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

   prog_loader #(.ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .count    (count),
      .overflow (overflow),
`ifdef PROG_LOADER_CHECKSUM_EN
      .checksum (checksum),
`endif
      .curr     (curr)
   );

   // Clock: rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_curr"},     curr, 0);
      check({tag, "_in_ready"}, bus.in_ready, 1);
      check({tag, "_mem_we"},   bus.mem_we, 0);
      check({tag, "_mem_addr"}, bus.mem_addr, 0);
      check({tag, "_mem_wdata"},bus.mem_wdata, 0);
      check({tag, "_S"},        bus.S, 0);
      check({tag, "_count"},    count, 0);
      check({tag, "_overflow"}, overflow, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
      check({tag, "_checksum"}, checksum, 0);
`endif
   endtask

   // Driver: called at a falling edge; transfers on the next rising edge and
   // returns at the following falling edge.
   task automatic send(input logic [3:0] op, input logic [3:0] dst,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic last, input logic wr, input logic [3:0] addr);
      check("in_ready_before_xfer", bus.in_ready, 1);
      bus.in_valid  = 1'b1;
      bus.in_opcode = op;
      bus.in_dest   = dst;
      bus.in_src1   = s1;
      bus.in_src2   = s2;
      bus.in_last   = last;
      if (wr) exp_q.push_back({addr, op, dst, s1, s2});
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Scoreboard: every write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (!reset && bus.mem_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", bus.mem_addr, 32'hFFFF_FFFF);
         end else begin
            logic [ADDR_W+15:0] e;
            e = exp_q.pop_front();
            check("write_addr", bus.mem_addr, e[ADDR_W+15:16]);
            check("write_data", bus.mem_wdata, e[15:0]);
         end
      end
   end

   initial begin
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_opcode = '0;
      bus.in_dest   = '0;
      bus.in_src1   = '0;
      bus.in_src2   = '0;
      bus.in_last   = 1'b0;
      bus.d         = 1'b0;

      // Power-on reset, checked before the first clock edge
      #1 reset = 1'b1;
      #1 check_reset_vals("por");
      @(negedge clk);
      reset = 1'b0;

      // Program 1: three words, last on the third
      send(4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 1'b1, 4'd0);
      check("p1_curr_load", curr, 1);
      check("p1_count1", count, 1);
      send(4'h5, 4'h6, 4'h7, 4'h8, 1'b0, 1'b1, 4'd1);
      check("p1_count2", count, 2);
`ifdef PROG_LOADER_CHECKSUM_EN
      check("p1_checksum2", checksum, 16'h444C);
`endif
      send(4'h9, 4'hA, 4'hB, 4'hC, 1'b1, 1'b1, 4'd2);
      check("p1_curr_flush", curr, 2);
      check("p1_ready_flush", bus.in_ready, 0);
      check("p1_S_flush", bus.S, 0);
      check("p1_count3", count, 3);
`ifdef PROG_LOADER_CHECKSUM_EN
      check("p1_checksum3", checksum, 16'hDEF0);
`endif
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("p1_curr_run", curr, 3);
         check("p1_S_run", bus.S, 1);
         check("p1_ready_run", bus.in_ready, 0);
      end
      bus.d = 1'b1;
      @(negedge clk);
      bus.d = 1'b0;
      check("p1_curr_done", curr, 0);
      check("p1_S_done", bus.S, 0);
      check("p1_ready_done", bus.in_ready, 1);
      check("p1_count_hold", count, 3);

      // Program 2: d held high in IDLE and LOAD, still high on entering RUN
      bus.d = 1'b1;
      repeat (2) @(negedge clk);
      check("p2_idle_d", curr, 0);
      send(4'hF, 4'hE, 4'hD, 4'hC, 1'b0, 1'b1, 4'd0);
      check("p2_curr_load", curr, 1);
      check("p2_count1", count, 1);
`ifdef PROG_LOADER_CHECKSUM_EN
      check("p2_checksum_restart", checksum, 16'hFEDC);
`endif
      @(negedge clk);
      check("p2_load_d", curr, 1);
      send(4'h0, 4'h1, 4'h2, 4'h3, 1'b1, 1'b1, 4'd1);
      check("p2_curr_flush", curr, 2);
      @(negedge clk);
      check("p2_curr_run", curr, 3);
      check("p2_S_run", bus.S, 1);
      @(negedge clk);
      check("p2_curr_idle", curr, 0);
      check("p2_S_one_cycle", bus.S, 0);
      bus.d = 1'b0;

      // Program 3: 18 words with random stalls; the last two are dropped
      for (int i = 0; i < 18; i++) begin
         int gap;
         logic [3:0] a;
         gap = $urandom_range(0, 2);
         a = 4'(i);
         repeat (gap) @(negedge clk);
         send(a, ~a, a + 4'd1, 4'h5, (i == 17), (i < 16), a);
         if (i == 15) begin
            check("p3_count_full", count, 16);
            check("p3_overflow_clear", overflow, 0);
         end
         if (i == 16) begin
            check("p3_count_sat", count, 16);
            check("p3_overflow_set", overflow, 1);
            check("p3_curr_load", curr, 1);
         end
      end
      check("p3_curr_flush", curr, 2);
      check("p3_count_final", count, 16);
      check("p3_overflow_final", overflow, 1);
      @(negedge clk);
      check("p3_S_run", bus.S, 1);
      bus.d = 1'b1;
      @(negedge clk);
      bus.d = 1'b0;
      check("p3_curr_idle", curr, 0);
      check("p3_overflow_hold", overflow, 1);
      check("p3_count_hold", count, 16);

      // Program 4: reset asserted between edges while in RUN
      send(4'h2, 4'h4, 4'h6, 4'h8, 1'b0, 1'b1, 4'd0);
      check("p4_overflow_cleared", overflow, 0);
      check("p4_count1", count, 1);
      send(4'h3, 4'h5, 4'h7, 4'h9, 1'b1, 1'b1, 4'd1);
      @(negedge clk);
      check("p4_curr_run", curr, 3);
      #2 reset = 1'b1;
      #1 check_reset_vals("rst_run");
      @(negedge clk);
      reset = 1'b0;

      // Program 5: reset asserted between edges while in LOAD
      send(4'h7, 4'h7, 4'h7, 4'h7, 1'b0, 1'b1, 4'd0);
      send(4'h8, 4'h8, 4'h8, 4'h8, 1'b0, 1'b1, 4'd1);
      check("p5_curr_load", curr, 1);
      #2 reset = 1'b1;
      #1 check_reset_vals("rst_load");
      @(negedge clk);
      reset = 1'b0;

      // Program 6: fresh single-word program starts at address 0
      send(4'hC, 4'h0, 4'hF, 4'hE, 1'b1, 1'b1, 4'd0);
      check("p6_curr_flush", curr, 2);
      check("p6_count", count, 1);
      @(negedge clk);
      check("p6_S_run", bus.S, 1);
      bus.d = 1'b1;
      @(negedge clk);
      bus.d = 1'b0;
      check("p6_curr_idle", curr, 0);

      repeat (2) @(negedge clk);
      check("pending_writes", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
